// File: rtl/buffer_pkg.sv
// Shared types for the sample buffer: the sample word, the read FSM states
// and the arbiter priority token.
package buffer_pkg;

  typedef logic [15:0] pkt_t;

  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {WRITE, READ}   prio_t;

endpackage

// File: rtl/sample_spram.sv
// Single-port sample RAM, one access per cycle, registered read data.
// Written so synthesis can map it straight onto a block RAM.
module sample_spram
  import buffer_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  pkt_t              wdata_i,
  output pkt_t              rdata_o
);

  pkt_t mem [DEPTH];
  pkt_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_buf_ctrl.sv
// FIFO controller sharing one single-port sample RAM between producer and
// consumer, with a registered valid/ready read port.
//
//   state   | meaning
//   IDLE    | no RAM read outstanding; a read may be granted
//   RD_WAIT | RAM read issued last cycle; load its data into the output reg
module sample_buf_ctrl
  import buffer_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            wr_valid,
  input  pkt_t            wr_data,
  output logic            wr_ready,
  output logic            rd_valid,
  output pkt_t            rd_data,
  input  logic            rd_ready,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  prio_t             prio_q, prio_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  pkt_t              rd_data_q, rd_data_d;

  logic              clear;
  logic              rd_req, wr_req;
  logic              grant_wr, grant_rd;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  pkt_t              ram_rdata;

  assign clear  = reset | flush;
  assign rd_req = (state_q == IDLE) && (count_q != '0) && (!rd_valid_q || rd_ready);
  assign wr_req = wr_valid && (count_q < DEPTH_C);

  // Contested cycles go to the priority holder; uncontested ones just win.
  assign grant_wr = wr_req && (!rd_req || (prio_q == WRITE));
  assign grant_rd = rd_req && (!wr_req || (prio_q == READ));

  assign ram_we   = grant_wr && !clear;
  assign ram_addr = grant_wr ? wr_ptr_q : rd_ptr_q;

  sample_spram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (grant_wr) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (grant_rd) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      state_d  = RD_WAIT;
    end

    case ({grant_wr, grant_rd})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_req && rd_req) prio_d = (prio_q == WRITE) ? READ : WRITE;

    // A read is only granted once the output reg is free or being consumed,
    // so the load below never overwrites an unconsumed word.
    if (state_q == RD_WAIT) begin
      rd_data_d  = ram_rdata;
      rd_valid_d = 1'b1;
      state_d    = IDLE;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      prio_q     <= WRITE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign wr_ready = (count_q < DEPTH_C) && !(rd_req && (prio_q == READ));
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign level    = count_q + (ADDR_W+1)'(state_q == RD_WAIT) + (ADDR_W+1)'(rd_valid_q);
  assign full     = (count_q == DEPTH_C);
  assign empty    = (level == '0);

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// Bench for sample_buf_ctrl: accepted writes feed an expected-data queue,
// a negedge monitor pops it on every consume and tracks level against it.
module tb_sample_buf_ctrl;
  import buffer_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  pkt_t       wr_data = '0;
  logic       wr_ready;
  logic       rd_valid;
  pkt_t       rd_data;
  logic       rd_ready = 1'b0;
  logic [4:0] level;
  logic       full;
  logic       empty;

  int   vectors = 0;
  int   miscompares = 0;
  pkt_t pkts [100];
  pkt_t exp_q [$];

  always #5 clk = ~clk;

  sample_buf_ctrl #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: level must equal words accepted but not yet consumed.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      chk("level_vs_model", 32'(level), 32'(exp_q.size()));
      chk("empty_vs_model", 32'(empty), 32'(exp_q.size() == 0));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got %0h expected no data", rd_data);
        end else begin
          chk("rd_data_order", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    end
  end

  task automatic do_reset();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
  endtask

  task automatic push_words(input int first, input int n, input int budget,
                            input bit rand_rd, input bit hold);
    int acc = 0;
    int cyc = 0;
    wr_valid = 1'b1;
    wr_data  = pkts[first % 100];
    while (acc < n && cyc < budget) begin
      @(negedge clk);
      if (wr_ready) acc++;
      @(posedge clk); #1;
      cyc++;
      wr_data = pkts[(first + acc) % 100];
      if (rand_rd) rd_ready = 1'($urandom_range(0, 1));
    end
    if (!hold) wr_valid = 1'b0;
    chk("push_accept_count", 32'(acc), 32'(n));
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while (level != '0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cyc;
    int exp_wr [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

    for (int i = 0; i < 100; i++)
      pkts[i] = (i == 0) ? 16'hAAAA : (i == 1) ? 16'hBBBB : 16'(16'h1000 + i);

    // Reset held two cycles with a write pending
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Fill with consumer stalled
    do_reset();
    push_words(0, 17, 100, 1'b0, 1'b1);
    @(negedge clk);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd17);
    chk("fill_rd_valid", 32'(rd_valid), 32'd1);
    chk("fill_rd_data", 32'(rd_data), 32'hAAAA);
    @(posedge clk); #1;
    drain(200);

    // Contention: grants alternate once both sides request
    do_reset();
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      wr_data = pkts[40 + acc];
      @(negedge clk);
      chk($sformatf("contend_wr_ready_c%0d", c), 32'(wr_ready), 32'(exp_wr[c]));
      if (wr_ready) acc++;
      @(posedge clk); #1;
    end
    drain(200);

    // Full stream with random consumer
    do_reset();
    push_words(0, 100, 3000, 1'b1, 1'b0);
    drain(500);

    // Flush while a read is in flight
    do_reset();
    push_words(30, 5, 50, 1'b0, 1'b0);
    rd_ready = 1'b1;
    @(negedge clk);
    chk("flush_pre_level", 32'(level), 32'd5);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    @(negedge clk);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("flush_no_stale", 32'(rd_valid), 32'd0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    @(negedge clk);
    chk("flush_next_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("flush_first_out", 32'(rd_data), 32'h1234);
    drain(50);

    // Underflow: consumer ready on an empty buffer
    rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("underflow_rd_valid", 32'(rd_valid), 32'd0);
      chk("underflow_empty", 32'(empty), 32'd1);
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    push_words(99, 1, 10, 1'b0, 1'b0);
    cyc = 0;
    while (!rd_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("underflow_next_out", 32'(rd_data), 32'h1063);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
